// File: rtl/pe_pkg.sv
// Shared types and default constants for the systolic PE accumulator stage.
// Optional feature macro: PE_ACC_SATURATE_EN (clamp instead of wrap on overflow).
package pe_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pe_acc_state_t;

  localparam int unsigned PE_BITS_DEF     = 16;
  localparam int unsigned PE_ACC_BITS_DEF = 40;
  localparam int unsigned PE_CNT_BITS_DEF = 8;

  // Saturation limits for the default accumulator width.
  localparam logic [PE_ACC_BITS_DEF-1:0] PE_ACC_MAX_DEF = {1'b0, {(PE_ACC_BITS_DEF-1){1'b1}}};
  localparam logic [PE_ACC_BITS_DEF-1:0] PE_ACC_MIN_DEF = {1'b1, {(PE_ACC_BITS_DEF-1){1'b0}}};

endpackage

// File: rtl/acc_add_sat.sv
// Combinational signed adder with overflow flag.
// With PE_ACC_SATURATE_EN defined the result clamps to the signed range limits.
module acc_add_sat #(
  parameter int unsigned ACC_BITS = 40
) (
  input  logic [ACC_BITS-1:0] a_i,
  input  logic [ACC_BITS-1:0] b_i,
  output logic [ACC_BITS-1:0] sum_o,
  output logic                ovf_o
);

  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  logic [ACC_BITS-1:0] raw;

  // Raw sum and overflow: equal operand signs, differing result sign.
  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[ACC_BITS-1] == b_i[ACC_BITS-1]) && (raw[ACC_BITS-1] != a_i[ACC_BITS-1]);
`ifdef PE_ACC_SATURATE_EN
    if (ovf_o) sum_o = b_i[ACC_BITS-1] ? ACC_MIN : ACC_MAX;
    else       sum_o = raw;
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/pe_accumulator.sv
// Accumulates signed products into a dot-product segment sum and presents
// the finished sum on a valid/ready port. Segment ends on prod_last.
// Optional feature macro: PE_ACC_SATURATE_EN (clamp instead of wrap on overflow).
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned BITS     = PE_BITS_DEF,
  parameter int unsigned ACC_BITS = PE_ACC_BITS_DEF,
  parameter int unsigned CNT_BITS = PE_CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prod_valid,
  output logic                prod_ready,
  input  logic [2*BITS-1:0]   product,
  input  logic                prod_last,
  output logic                acc_valid,
  input  logic                acc_ready,
  output logic [ACC_BITS-1:0] acc_out,
  output logic [CNT_BITS-1:0] acc_count,
  output logic                acc_ovf
);

  pe_acc_state_t       state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [ACC_BITS-1:0] out_acc_q, out_acc_d;
  logic [CNT_BITS-1:0] out_cnt_q, out_cnt_d;
  logic                out_ovf_q, out_ovf_d;

  logic [ACC_BITS-1:0] prod_ext;
  logic [ACC_BITS-1:0] add_sum;
  logic                add_ovf;
  logic [CNT_BITS-1:0] cnt_inc;

  assign prod_ext = ACC_BITS'($signed(product));
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BITS'(1);

  acc_add_sat #(
    .ACC_BITS(ACC_BITS)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  // Next-state logic: accumulate in ACCUM, present and wait in HOLD.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (prod_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (prod_last) begin
            out_acc_d = add_sum;
            out_cnt_d = cnt_inc;
            out_ovf_d = ovf_q | add_ovf;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers; reset discards any partial segment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_acc_q <= out_acc_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign acc_valid  = (state_q == HOLD);
  assign acc_out    = out_acc_q;
  assign acc_count  = out_cnt_q;
  assign acc_ovf    = out_ovf_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed self-checking bench for pe_accumulator. Three instances share the
// stimulus: default parameters, ACC_BITS=32, and CNT_BITS=2.
module tb_pe_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        prod_valid;
  logic [31:0] product;
  logic        prod_last;
  logic        acc_ready;

  logic        prod_ready, acc_valid, acc_ovf;
  logic [39:0] acc_out;
  logic [7:0]  acc_count;

  logic        prod_ready32, acc_valid32, acc_ovf32;
  logic [31:0] acc_out32;
  logic [7:0]  acc_count32;

  logic        prod_readyc, acc_validc, acc_ovfc;
  logic [39:0] acc_outc;
  logic [1:0]  acc_countc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_accumulator #(.BITS(16), .ACC_BITS(40), .CNT_BITS(8)) u_dut (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .product(product), .prod_last(prod_last), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_out(acc_out), .acc_count(acc_count), .acc_ovf(acc_ovf)
  );

  pe_accumulator #(.BITS(16), .ACC_BITS(32), .CNT_BITS(8)) u_dut32 (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .prod_ready(prod_ready32),
    .product(product), .prod_last(prod_last), .acc_valid(acc_valid32),
    .acc_ready(acc_ready), .acc_out(acc_out32), .acc_count(acc_count32), .acc_ovf(acc_ovf32)
  );

  pe_accumulator #(.BITS(16), .ACC_BITS(40), .CNT_BITS(2)) u_dutc (
    .clk(clk), .reset(reset), .prod_valid(prod_valid), .prod_ready(prod_readyc),
    .product(product), .prod_last(prod_last), .acc_valid(acc_validc),
    .acc_ready(acc_ready), .acc_out(acc_outc), .acc_count(acc_countc), .acc_ovf(acc_ovfc)
  );

  // Present one product for one cycle; it is accepted at the next edge.
  task automatic push(input logic [31:0] val, input logic last);
    prod_valid = 1'b1;
    product    = val;
    prod_last  = last;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    product    = '0;
  endtask

  // One cycle with acc_ready high to complete the output handshake.
  task automatic release_sum;
    acc_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; prod_valid = 1'b0; prod_last = 1'b0; product = '0; acc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", acc_valid); end
    n_checks++;
    if (acc_out !== 40'd0 || acc_count !== 8'd0 || acc_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got out=%0d cnt=%0d ovf=%b expected 0 0 0", acc_out, acc_count, acc_ovf);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (prod_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b expected 1", prod_ready); end
  endtask

  task automatic test_basic_segment;
    push(32'd100, 1'b0);
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL basic_midvalid got %b expected 0", acc_valid); end
    push(-32'sd30, 1'b0);
    push(32'd7, 1'b1);
    n_checks++;
    if (acc_valid !== 1'b1 || prod_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency got valid=%b ready=%b expected 1 0", acc_valid, prod_ready);
    end
    n_checks++;
    if ($signed(acc_out) !== 40'sd77 || acc_count !== 8'd3 || acc_ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum got out=%0d cnt=%0d ovf=%b expected 77 3 0", $signed(acc_out), acc_count, acc_ovf);
    end
    release_sum();
    n_checks++;
    if (acc_valid !== 1'b0 || prod_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_after_hs got valid=%b ready=%b expected 0 1", acc_valid, prod_ready);
    end
    n_checks++;
    if ($signed(acc_out) !== 40'sd77 || acc_count !== 8'd3) begin
      n_fail++; $display("FAIL basic_retain got out=%0d cnt=%0d expected 77 3", $signed(acc_out), acc_count);
    end
  endtask

  task automatic test_backpressure;
    acc_ready = 1'b0;
    push(-32'sd1073709056, 1'b1);
    // A product offered while holding must be ignored.
    prod_valid = 1'b1; product = 32'd12345; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (acc_valid !== 1'b1 || prod_ready !== 1'b0 || $signed(acc_out) !== -40'sd1073709056 || acc_count !== 8'd1) begin
        n_fail++; $display("FAIL hold_cycle%0d got valid=%b ready=%b out=%0d cnt=%0d expected 1 0 -1073709056 1",
                           i, acc_valid, prod_ready, $signed(acc_out), acc_count);
      end
      @(posedge clk); #1;
    end
    prod_valid = 1'b0; product = '0; prod_last = 1'b0;
    release_sum();
    n_checks++;
    if (acc_valid !== 1'b0 || prod_ready !== 1'b1 || $signed(acc_out) !== -40'sd1073709056) begin
      n_fail++; $display("FAIL hold_release got valid=%b ready=%b out=%0d expected 0 1 -1073709056",
                         acc_valid, prod_ready, $signed(acc_out));
    end
  endtask

  task automatic test_overflow;
    logic [31:0] exp32;
`ifdef PE_ACC_SATURATE_EN
    exp32 = 32'h7FFF_FFFF;
`else
    exp32 = 32'h0000_0000;
`endif
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b1);
    n_checks++;
    if (acc_valid32 !== 1'b1 || acc_out32 !== exp32 || acc_ovf32 !== 1'b1 || acc_count32 !== 8'd4) begin
      n_fail++; $display("FAIL ovf_acc32 got valid=%b out=%h ovf=%b cnt=%0d expected 1 %h 1 4",
                         acc_valid32, acc_out32, acc_ovf32, acc_count32, exp32);
    end
    n_checks++;
    if (acc_out !== 40'h01_0000_0000 || acc_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_acc40 got out=%h ovf=%b expected 0100000000 0", acc_out, acc_ovf);
    end
    release_sum();
    // Next segment must start with ovf cleared.
    push(32'd3, 1'b1);
    n_checks++;
    if (acc_out32 !== 32'd3 || acc_ovf32 !== 1'b0 || acc_count32 !== 8'd1) begin
      n_fail++; $display("FAIL ovf_cleared got out=%0d ovf=%b cnt=%0d expected 3 0 1", acc_out32, acc_ovf32, acc_count32);
    end
    release_sum();
  endtask

  task automatic test_count_saturation;
    for (int i = 0; i < 6; i++) push(32'd1, (i == 5));
    n_checks++;
    if (acc_validc !== 1'b1 || acc_outc !== 40'd6 || acc_countc !== 2'd3) begin
      n_fail++; $display("FAIL cnt_sat got valid=%b out=%0d cnt=%0d expected 1 6 3", acc_validc, acc_outc, acc_countc);
    end
    n_checks++;
    if (acc_count !== 8'd6) begin n_fail++; $display("FAIL cnt_wide got %0d expected 6", acc_count); end
    release_sum();
  endtask

  task automatic test_reset_mid_segment;
    push(32'd5, 1'b0);
    push(32'd5, 1'b0);
    reset = 1'b1;
    #2;
    n_checks++;
    if (acc_valid !== 1'b0 || acc_out !== 40'd0 || acc_count !== 8'd0 || acc_ovf !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async got valid=%b out=%0d cnt=%0d ovf=%b expected 0 0 0 0",
                         acc_valid, acc_out, acc_count, acc_ovf);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (prod_ready !== 1'b1 || acc_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ready got ready=%b valid=%b expected 1 0", prod_ready, acc_valid);
    end
    push(32'd9, 1'b1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== 40'd9 || acc_count !== 8'd1) begin
      n_fail++; $display("FAIL midrst_sum got valid=%b out=%0d cnt=%0d expected 1 9 1", acc_valid, acc_out, acc_count);
    end
    release_sum();
  endtask

  task automatic test_stray_last;
    prod_valid = 1'b0; prod_last = 1'b1; product = 32'd999;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL stray_last%0d got %b expected 0", i, acc_valid); end
    end
    push(32'd4, 1'b0);
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL stray_nolast got %b expected 0", acc_valid); end
    push(32'd6, 1'b1);
    n_checks++;
    if (acc_out !== 40'd10 || acc_count !== 8'd2 || acc_valid !== 1'b1) begin
      n_fail++; $display("FAIL stray_sum got out=%0d cnt=%0d valid=%b expected 10 2 1", acc_out, acc_count, acc_valid);
    end
    release_sum();
  endtask

  initial begin
    test_reset();
    test_basic_segment();
    test_backpressure();
    test_overflow();
    test_count_saturation();
    test_reset_mid_segment();
    test_stray_last();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
